// File: rtl/cook_sequencer.sv
// Oven cook-session sequencer: door interlock, power duty cycling, pause/resume/cancel, end beep.
// Defining CHILD_LOCK_EN adds a child lock, toggled by holding stop in IDLE for three ticks.
module cook_sequencer #(
  parameter int DUTY_WINDOW = 10,
  parameter int MAX_POWER   = 10,
  parameter int BEEP_TICKS  = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic       power_key,
  input  logic       opened_door,
  input  logic       timer_zero,
  output logic       magnetron,
  output logic       timer_en,
  output logic       timer_clear,
  output logic       beep,
  output logic [1:0] state,
  output logic [3:0] power_level
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COOK  = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t     state_r;
  logic       start_q, stop_q, clear_q, power_q;
  logic       start_ev_s, stop_ev_s, clear_ev_s, power_ev_s;
  logic [3:0] duty_r;
  logic [7:0] beep_cnt_r;
  logic       magnetron_r, timer_en_r, timer_clear_r, beep_r;
  logic [3:0] power_level_r;
  logic       locked_s;

`ifdef CHILD_LOCK_EN
  logic       lock_r;
  logic [1:0] lock_cnt_r;
  assign locked_s = lock_r;
`else
  assign locked_s = 1'b0;
`endif

  assign start_ev_s = start & ~start_q;
  assign stop_ev_s  = stop & ~stop_q;
  assign clear_ev_s = clear & ~clear_q;
  assign power_ev_s = power_key & ~power_q;

  // Door interlock is also applied combinationally so an opening door cuts power in the same cycle.
  assign magnetron   = magnetron_r & ~opened_door;
  assign timer_en    = timer_en_r;
  assign timer_clear = timer_clear_r;
  assign beep        = beep_r;
  assign state       = state_r;
  assign power_level = power_level_r;

  // Session FSM with button edge detection and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= IDLE;
      start_q       <= 1'b0;
      stop_q        <= 1'b0;
      clear_q       <= 1'b0;
      power_q       <= 1'b0;
      duty_r        <= 4'd0;
      beep_cnt_r    <= 8'd0;
      magnetron_r   <= 1'b0;
      timer_en_r    <= 1'b0;
      timer_clear_r <= 1'b0;
      beep_r        <= 1'b0;
      power_level_r <= 4'(MAX_POWER);
`ifdef CHILD_LOCK_EN
      lock_r        <= 1'b0;
      lock_cnt_r    <= 2'd0;
`endif
    end else begin
      start_q       <= start;
      stop_q        <= stop;
      clear_q       <= clear;
      power_q       <= power_key;
      timer_clear_r <= 1'b0;
`ifdef CHILD_LOCK_EN
      if (state_r != IDLE) begin
        lock_cnt_r <= 2'd0;
      end
`endif
      case (state_r)
        IDLE: begin
          beep_r      <= 1'b0;
          magnetron_r <= 1'b0;
          timer_en_r  <= 1'b0;
          if (clear_ev_s) begin
            timer_clear_r <= 1'b1;
          end else if (start_ev_s && !stop_ev_s) begin
            if (!locked_s && !opened_door && !timer_zero) begin
              state_r     <= COOK;
              duty_r      <= 4'd0;
              timer_en_r  <= 1'b1;
              magnetron_r <= 1'b1;
            end
          end else if (power_ev_s && !stop_ev_s && !locked_s) begin
            if (power_level_r <= 4'd1) begin
              power_level_r <= 4'(MAX_POWER);
            end else begin
              power_level_r <= power_level_r - 4'd1;
            end
          end
`ifdef CHILD_LOCK_EN
          // Stop held across three consecutive ticks flips the lock; beep flags each toggle.
          if (!stop) begin
            lock_cnt_r <= 2'd0;
          end else if (tick_1hz) begin
            if (lock_cnt_r == 2'd2) begin
              lock_r     <= ~lock_r;
              lock_cnt_r <= 2'd0;
              beep_r     <= 1'b1;
            end else begin
              lock_cnt_r <= lock_cnt_r + 2'd1;
            end
          end
`endif
        end
        COOK: begin
          if (clear_ev_s) begin
            state_r       <= IDLE;
            timer_clear_r <= 1'b1;
            timer_en_r    <= 1'b0;
            magnetron_r   <= 1'b0;
          end else if (timer_zero) begin
            state_r     <= DONE;
            beep_r      <= 1'b1;
            beep_cnt_r  <= 8'd0;
            timer_en_r  <= 1'b0;
            magnetron_r <= 1'b0;
          end else if (opened_door || stop_ev_s) begin
            state_r     <= PAUSE;
            timer_en_r  <= 1'b0;
            magnetron_r <= 1'b0;
          end else begin
            magnetron_r <= (duty_r < power_level_r);
            if (tick_1hz) begin
              if (duty_r >= 4'(DUTY_WINDOW - 1)) begin
                duty_r <= 4'd0;
              end else begin
                duty_r <= duty_r + 4'd1;
              end
            end
          end
        end
        PAUSE: begin
          timer_en_r  <= 1'b0;
          magnetron_r <= 1'b0;
          if (clear_ev_s || stop_ev_s) begin
            state_r       <= IDLE;
            timer_clear_r <= 1'b1;
          end else if (start_ev_s && !opened_door) begin
            state_r     <= COOK;
            timer_en_r  <= 1'b1;
            magnetron_r <= (duty_r < power_level_r);
          end
        end
        DONE: begin
          timer_en_r  <= 1'b0;
          magnetron_r <= 1'b0;
          if (clear_ev_s || stop_ev_s || opened_door) begin
            state_r       <= IDLE;
            beep_r        <= 1'b0;
            beep_cnt_r    <= 8'd0;
            timer_clear_r <= clear_ev_s;
          end else if (tick_1hz) begin
            if (beep_cnt_r >= 8'(BEEP_TICKS - 1)) begin
              state_r    <= IDLE;
              beep_r     <= 1'b0;
              beep_cnt_r <= 8'd0;
            end else begin
              beep_cnt_r <= beep_cnt_r + 8'd1;
            end
          end
        end
        default: begin
          state_r     <= IDLE;
          timer_en_r  <= 1'b0;
          magnetron_r <= 1'b0;
          beep_r      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cook_sequencer.sv
// Directed self-checking bench for cook_sequencer with hand-computed expectations.
module tb_cook_sequencer;

  logic       clk = 1'b0;
  logic       reset, tick_1hz, start, stop, clear, power_key, opened_door, timer_zero;
  logic       magnetron, timer_en, timer_clear, beep;
  logic [1:0] state;
  logic [3:0] power_level;

  int n_checks = 0;
  int n_fail   = 0;
  int duty_m;

  cook_sequencer dut (
    .clk(clk), .reset(reset), .tick_1hz(tick_1hz), .start(start), .stop(stop),
    .clear(clear), .power_key(power_key), .opened_door(opened_door),
    .timer_zero(timer_zero), .magnetron(magnetron), .timer_en(timer_en),
    .timer_clear(timer_clear), .beep(beep), .state(state), .power_level(power_level)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick();
    tick_1hz = 1'b1;
    cyc(1);
    tick_1hz = 1'b0;
    cyc(1);
  endtask

  task automatic press_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(1);
  endtask

  task automatic press_power();
    power_key = 1'b1;
    cyc(1);
    power_key = 1'b0;
    cyc(1);
  endtask

  initial begin
    reset = 1'b1; tick_1hz = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0;
    power_key = 1'b0; opened_door = 1'b0; timer_zero = 1'b0;
    cyc(2);
    reset = 1'b0;
    check_eq("rst_state", state, 0);
    check_eq("rst_mag", magnetron, 0);
    check_eq("rst_ten", timer_en, 0);
    check_eq("rst_tclr", timer_clear, 0);
    check_eq("rst_beep", beep, 0);
    check_eq("rst_power", power_level, 10);

    // Full power cook then completion beep
    start = 1'b1;
    cyc(1);
    check_eq("full_state", state, 1);
    check_eq("full_ten", timer_en, 1);
    check_eq("full_mag0", magnetron, 1);
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      check_eq("full_mag", magnetron, 1);
    end
    timer_zero = 1'b1;
    cyc(1);
    check_eq("done_state", state, 3);
    check_eq("done_beep", beep, 1);
    check_eq("done_mag", magnetron, 0);
    check_eq("done_ten", timer_en, 0);
    tick();
    tick();
    check_eq("beep_t2_state", state, 3);
    check_eq("beep_t2", beep, 1);
    tick();
    check_eq("beep_end_state", state, 0);
    check_eq("beep_end", beep, 0);
    timer_zero = 1'b0;

    // Reduced power 10 -> 3 with wrap-free decrements
    for (int i = 0; i < 7; i++) press_power();
    check_eq("power3", power_level, 3);
    press_start();
    check_eq("p3_state", state, 1);
    check_eq("p3_mag_start", magnetron, 1);
    duty_m = 0;
    for (int i = 0; i < 22; i++) begin
      tick();
      duty_m = (duty_m + 1) % 10;
      check_eq("p3_mag", magnetron, (duty_m < 3) ? 1 : 0);
    end
    press_power();
    check_eq("cook_pk_ignored", power_level, 3);

    // Door opens while magnetron is on (duty 2)
    check_eq("pre_door_mag", magnetron, 1);
    opened_door = 1'b1;
    #1;
    check_eq("door_mag_same", magnetron, 0);
    cyc(1);
    check_eq("door_state", state, 2);
    check_eq("door_ten", timer_en, 0);
    opened_door = 1'b0;
    cyc(2);
    check_eq("pause_mag", magnetron, 0);
    press_start();
    check_eq("resume_state", state, 1);
    check_eq("resume_mag", magnetron, 1);
    tick();
    check_eq("resume_duty3", magnetron, 0);
    for (int i = 0; i < 7; i++) tick();
    check_eq("resume_wrap", magnetron, 1);

    // stop and timer_zero together in COOK: DONE wins
    stop = 1'b1; timer_zero = 1'b1;
    cyc(1);
    check_eq("stop_tz_state", state, 3);
    stop = 1'b0;
    cyc(1);
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    check_eq("done_clear_state", state, 0);
    timer_zero = 1'b0;
    cyc(1);

    // clear and start together in IDLE
    clear = 1'b1; start = 1'b1;
    cyc(1);
    check_eq("cs_tclr", timer_clear, 1);
    check_eq("cs_state", state, 0);
    clear = 1'b0; start = 1'b0;
    cyc(1);
    check_eq("cs_tclr_width", timer_clear, 0);
    check_eq("cs_state2", state, 0);

    // Reset while cooking
    press_start();
    check_eq("pre_rst_mag", magnetron, 1);
    reset = 1'b1;
    cyc(1);
    check_eq("mrst_mag", magnetron, 0);
    check_eq("mrst_state", state, 0);
    check_eq("mrst_ten", timer_en, 0);
    check_eq("mrst_beep", beep, 0);
    check_eq("mrst_power", power_level, 10);
    reset = 1'b0;
    cyc(1);

    // Rejected starts
    timer_zero = 1'b1;
    press_start();
    check_eq("rej_tz", state, 0);
    timer_zero = 1'b0;
    opened_door = 1'b1;
    press_start();
    check_eq("rej_door", state, 0);
    opened_door = 1'b0;
    cyc(1);

    // Held start resumes only once
    press_start();
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    check_eq("hold_pause", state, 2);
    start = 1'b1;
    cyc(1);
    check_eq("hold_resume", state, 1);
    cyc(3);
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    check_eq("hold_pause2", state, 2);
    cyc(15);
    check_eq("hold_no_rerun", state, 2);
    start = 1'b0;
    cyc(1);
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    check_eq("pause_stop_state", state, 0);
    check_eq("pause_stop_tclr", timer_clear, 1);
    cyc(1);
    check_eq("pause_stop_tclr_end", timer_clear, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
